// File: rtl/pipe_reg_master.sv
// Bus master for a bank of sel/wr pipeline registers: turns one handshaked
// request at a time into single-cycle write, read or copy accesses plus a one-cycle response.
module pipe_reg_master #(
    parameter int WIDTH = 32,
    parameter int NREG  = 4,
    parameter int AW    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [AW-1:0]         req_addr,
    input  logic [AW-1:0]         req_src,
    input  logic [WIDTH-1:0]      req_wdata,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic [NREG-1:0]       reg_sel,
    output logic                  reg_wr,
    output logic [WIDTH-1:0]      reg_wdata,
    input  logic [NREG*WIDTH-1:0] reg_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        COPY_RD,
        COPY_WR,
        RESP
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;
    localparam logic [AW:0] NREG_W  = (AW+1)'(NREG);

    state_t           state;
    logic [AW-1:0]    addr_q;
    logic [AW-1:0]    src_q;
    logic [WIDTH-1:0] hold;
    logic             req_bad;

    function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] idx);
        onehot = '0;
        for (int k = 0; k < NREG; k++)
            if (idx == AW'(k))
                onehot[k] = 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] slice(input logic [NREG*WIDTH-1:0] bus,
                                               input logic [AW-1:0] idx);
        slice = '0;
        for (int k = 0; k < NREG; k++)
            if (idx == AW'(k))
                slice = bus[k*WIDTH +: WIDTH];
    endfunction

    // Out-of-range registers cannot be selected, so these requests short-cut to an error response.
    always_comb begin
        req_bad = (req_op == OP_ILL)
               || ({1'b0, req_addr} >= NREG_W)
               || ((req_op == OP_COPY) && ({1'b0, req_src} >= NREG_W));
    end

    // All outputs are loaded on the same edge that enters the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            src_q     <= '0;
            hold      <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            reg_sel   <= '0;
            reg_wr    <= 1'b0;
            reg_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        addr_q    <= req_addr;
                        src_q     <= req_src;
                        if (req_bad) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end else if (req_op == OP_WRITE) begin
                            state     <= WRITE;
                            reg_sel   <= onehot(req_addr);
                            reg_wr    <= 1'b1;
                            reg_wdata <= req_wdata;
                        end else if (req_op == OP_READ) begin
                            state   <= READ;
                            reg_sel <= onehot(req_addr);
                        end else begin
                            state   <= COPY_RD;
                            reg_sel <= onehot(req_src);
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WRITE: begin
                    state     <= RESP;
                    reg_sel   <= '0;
                    reg_wr    <= 1'b0;
                    reg_wdata <= '0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_data  <= '0;
                end
                READ: begin
                    state     <= RESP;
                    reg_sel   <= '0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_data  <= slice(reg_rdata, addr_q);
                end
                COPY_RD: begin
                    // The hold register is not loaded yet, so the write data comes straight from the bus.
                    state     <= COPY_WR;
                    hold      <= slice(reg_rdata, src_q);
                    reg_sel   <= onehot(addr_q);
                    reg_wr    <= 1'b1;
                    reg_wdata <= slice(reg_rdata, src_q);
                end
                COPY_WR: begin
                    state     <= RESP;
                    reg_sel   <= '0;
                    reg_wr    <= 1'b0;
                    reg_wdata <= '0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_data  <= hold;
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    reg_sel   <= '0;
                    reg_wr    <= 1'b0;
                    reg_wdata <= '0;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_reg_master.sv
// Directed bench for pipe_reg_master with a behavioural sel/wr register bank.
module tb_pipe_reg_master;

    localparam int WIDTH = 32;
    localparam int NREG  = 4;
    localparam int AW    = 3;

    logic                  clk;
    logic                  reset;
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [AW-1:0]         req_addr;
    logic [AW-1:0]         req_src;
    logic [WIDTH-1:0]      req_wdata;
    logic                  rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_err;
    logic [NREG-1:0]       reg_sel;
    logic                  reg_wr;
    logic [WIDTH-1:0]      reg_wdata;
    logic [NREG*WIDTH-1:0] reg_rdata;

    logic [WIDTH-1:0] bank [NREG];
    logic             bank_init;
    int               n_checks;
    int               n_fail;
    int               wr_cnt;
    int               rsp_cnt;
    int               hot_cnt;

    pipe_reg_master #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_src   (req_src),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .reg_sel   (reg_sel),
        .reg_wr    (reg_wr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank: combinational read of the selected slice, write on the clock edge.
    always_comb begin
        reg_rdata = '0;
        for (int k = 0; k < NREG; k++)
            if (reg_sel[k] && !reg_wr)
                reg_rdata[k*WIDTH +: WIDTH] = bank[k];
    end

    always @(posedge clk) begin
        for (int k = 0; k < NREG; k++) begin
            if (bank_init)
                bank[k] <= 32'h1000_0000 + k;
            else if (reg_sel[k] && reg_wr)
                bank[k] <= reg_wdata;
        end
    end

    always @(posedge clk) begin
        if (reg_wr) wr_cnt <= wr_cnt + 1;
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if ($countones(reg_sel) > 1) hot_cnt <= hot_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Presents one request once req_ready is seen and returns 1 time unit after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] s,
                         input logic [WIDTH-1:0] d);
        @(negedge clk);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        if (!req_ready) begin
            chk("issue_timeout", 64'd0, 64'd1);
            return;
        end
        req_op    = op;
        req_addr  = a;
        req_src   = s;
        req_wdata = d;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        int idx;
        int last;
        int wr0;
        int rsp0;
        logic acc;

        n_checks  = 0;
        n_fail    = 0;
        wr_cnt    = 0;
        rsp_cnt   = 0;
        hot_cnt   = 0;
        reset     = 1'b0;
        bank_init = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_addr  = '0;
        req_src   = '0;
        req_wdata = '0;

        #3;
        chk("rst_ready", req_ready, 0);
        chk("rst_outs", {rsp_valid, rsp_err, reg_sel, reg_wr}, 0);
        chk("rst_data", {rsp_data, reg_wdata}, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset     = 1'b1;
        bank_init = 1'b0;
        step;
        chk("idle_ready", req_ready, 1);

        // Write 0xDEADBEEF to reg 2.
        issue(2'b00, 3'd2, 3'd0, 32'hDEAD_BEEF);
        chk("wr_sel", reg_sel, 4'b0100);
        chk("wr_wr", reg_wr, 1);
        chk("wr_wdata", reg_wdata, 32'hDEAD_BEEF);
        chk("wr_noresp", rsp_valid, 0);
        step;
        chk("wr_bus_idle", {reg_sel, reg_wr}, 0);
        chk("wr_wdata_zero", reg_wdata, 0);
        chk("wr_rsp", {rsp_valid, rsp_err}, 2'b10);
        chk("wr_rsp_data", rsp_data, 0);
        chk("wr_bank2", bank[2], 32'hDEAD_BEEF);
        step;
        chk("wr_rsp_end", rsp_valid, 0);
        chk("wr_ready_back", req_ready, 1);

        // Read reg 2; write data on the request is ignored.
        issue(2'b01, 3'd2, 3'd0, 32'hFFFF_FFFF);
        chk("rd_sel", reg_sel, 4'b0100);
        chk("rd_wr", reg_wr, 0);
        chk("rd_wdata", reg_wdata, 0);
        step;
        chk("rd_rsp", {rsp_valid, rsp_err}, 2'b10);
        chk("rd_data", rsp_data, 32'hDEAD_BEEF);
        chk("rd_bus_idle", reg_sel, 0);

        // Copy reg 2 to reg 0.
        issue(2'b10, 3'd0, 3'd2, 32'h0);
        chk("cp_rd_sel", reg_sel, 4'b0100);
        chk("cp_rd_wr", reg_wr, 0);
        step;
        chk("cp_wr_sel", reg_sel, 4'b0001);
        chk("cp_wr_wr", reg_wr, 1);
        chk("cp_wr_wdata", reg_wdata, 32'hDEAD_BEEF);
        chk("cp_wr_noresp", rsp_valid, 0);
        step;
        chk("cp_rsp", {rsp_valid, rsp_err}, 2'b10);
        chk("cp_rsp_data", rsp_data, 32'hDEAD_BEEF);
        chk("cp_bank0", bank[0], 32'hDEAD_BEEF);
        step;
        chk("cp_ready_back", req_ready, 1);
        issue(2'b01, 3'd0, 3'd0, 32'h0);
        step;
        chk("cp_readback", rsp_data, 32'hDEAD_BEEF);

        // Illegal op, out-of-range addr, out-of-range copy source.
        wr0 = wr_cnt;
        issue(2'b11, 3'd1, 3'd0, 32'h1234_5678);
        chk("ill_rsp", {rsp_valid, rsp_err}, 2'b11);
        chk("ill_data", rsp_data, 0);
        chk("ill_nosel", reg_sel, 0);
        step;
        chk("ill_rsp_end", rsp_valid, 0);
        chk("ill_err_hold", rsp_err, 1);
        chk("ill_ready", req_ready, 1);
        issue(2'b00, 3'd5, 3'd0, 32'h1234_5678);
        chk("oor_rsp", {rsp_valid, rsp_err}, 2'b11);
        chk("oor_nosel", reg_sel, 0);
        issue(2'b10, 3'd1, 3'd6, 32'h0);
        chk("oor_src_rsp", {rsp_valid, rsp_err}, 2'b11);
        chk("oor_src_nosel", reg_sel, 0);
        step;
        chk("err_no_writes", wr_cnt - wr0, 0);
        chk("err_bank1", bank[1], 32'h1000_0001);
        chk("err_bank3", bank[3], 32'h1000_0003);
        issue(2'b01, 3'd1, 3'd0, 32'h0);
        step;
        chk("err_clear", {rsp_valid, rsp_err}, 2'b10);
        chk("rd1_data", rsp_data, 32'h1000_0001);

        // Back-to-back writes with req_valid held high.
        step;
        step;
        wr0  = wr_cnt;
        rsp0 = rsp_cnt;
        idx  = 0;
        last = 0;
        req_valid = 1'b1;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            @(negedge clk);
            req_op    = 2'b00;
            req_addr  = AW'(idx);
            req_wdata = 32'hA5A5_0000 + idx;
            acc       = req_ready;
            @(posedge clk);
            if (acc) begin
                if (idx > 0) chk("b2b_gap", c - last, 3);
                last = c;
                idx++;
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_count", idx, 4);
        step;
        step;
        step;
        chk("b2b_writes", wr_cnt - wr0, 4);
        chk("b2b_resps", rsp_cnt - rsp0, 4);
        for (int k = 0; k < NREG; k++)
            chk("b2b_bank", bank[k], 32'hA5A5_0000 + k);

        // Reset asserted in the middle of the COPY_WR cycle (copy reg 1 to reg 3).
        issue(2'b10, 3'd3, 3'd1, 32'h0);
        step;
        chk("rst_cp_wr", {reg_sel, reg_wr}, 5'b10001);
        rsp0 = rsp_cnt;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async_bus", {reg_sel, reg_wr}, 0);
        chk("rst_async_wdata", reg_wdata, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step;
        chk("rst_no_resp", rsp_cnt - rsp0, 0);
        chk("rst_bank3", bank[3], 32'hA5A5_0003);
        chk("rst_ready", req_ready, 1);

        // Copy with src == addr writes the value back unchanged.
        issue(2'b10, 3'd1, 3'd1, 32'h0);
        chk("self_rd_sel", reg_sel, 4'b0010);
        step;
        chk("self_wr_wdata", reg_wdata, 32'hA5A5_0001);
        step;
        chk("self_rsp", {rsp_valid, rsp_err}, 2'b10);
        chk("self_data", rsp_data, 32'hA5A5_0001);
        chk("self_bank1", bank[1], 32'hA5A5_0001);

        chk("sel_onehot", hot_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
